// File: rtl/o_row_fetch_if.sv
// Handshake/bus bundle between the O-buffer row fetcher, its controller, the O-buffer and the transpose stage.
// The "slave" modport is the fetcher's view; "master" is everything around it.
interface o_row_fetch_if #(
    parameter int ROW_DIM    = 16,
    parameter int COL_DIM    = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    localparam int CNT_W = $clog2(COL_DIM) + 1;
    localparam int ROW_W = ROW_DIM * DATA_WIDTH;

    logic                  sig_start;
    logic [CNT_W-1:0]      B;
    logic [ADDR_WIDTH-1:0] O_base_addr;

    logic                  O_rd_en;
    logic [ADDR_WIDTH-1:0] O_rd_addr;
    logic [ROW_W-1:0]      O_rd_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [ROW_W-1:0]      out_data;

    logic                  busy;
    logic                  sig_end;

    modport master (
        output sig_start, B, O_base_addr, O_rd_data, out_ready,
        input  O_rd_en, O_rd_addr, out_valid, out_data, busy, sig_end
    );

    modport slave (
        input  sig_start, B, O_base_addr, O_rd_data, out_ready,
        output O_rd_en, O_rd_addr, out_valid, out_data, busy, sig_end
    );
endinterface

// File: rtl/o_row_fetch.sv
// Streams B consecutive O-buffer rows into a 2-entry FIFO feeding the transpose stage; first row out 3 cycles after start.
// Backpressure: out_ready low freezes the FIFO head and throttles reads so buffered plus in-flight rows never exceed 2.
module o_row_fetch #(
    parameter int ROW_DIM    = 16,
    parameter int COL_DIM    = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic          clk,
    input  logic          reset,
    o_row_fetch_if.slave  io
);
    localparam int CNT_W = $clog2(COL_DIM) + 1;
    localparam int ROW_W = ROW_DIM * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic [CNT_W-1:0]      b_q,         b_d;
    logic [CNT_W-1:0]      issued_q,    issued_d;
    logic [CNT_W-1:0]      deliv_q,     deliv_d;
    logic [ADDR_WIDTH-1:0] base_q,      base_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic                  inflight_q,  inflight_d;
    logic                  sig_end_q,   sig_end_d;

    logic [ROW_W-1:0]      mem_q [2];
    logic [ROW_W-1:0]      mem_d [2];
    logic                  wr_ptr_q,    wr_ptr_d;
    logic                  rd_ptr_q,    rd_ptr_d;
    logic [1:0]            occ_q,       occ_d;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [1:0]            level;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [CNT_W-1:0]      b_clamped;

    assign b_clamped = (io.B > CNT_W'(COL_DIM)) ? CNT_W'(COL_DIM) : io.B;

    // A response is only ever accepted in the cycle right after its read strobe.
    assign push      = inflight_q;
    assign pop       = (occ_q != 2'd0) && io.out_ready;
    assign level     = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign next_addr = base_q + ADDR_WIDTH'(issued_q);

    // Issue is decided in the same cycle as the pop so a draining consumer sustains one row per cycle.
    assign issue = (state_q == FETCH) && (issued_q < b_q) && (level < 2'd2);

    assign io.O_rd_en   = issue;
    assign io.O_rd_addr = issue ? next_addr : last_addr_q;
    assign io.out_valid = (occ_q != 2'd0);
    assign io.out_data  = mem_q[rd_ptr_q];
    assign io.busy      = (state_q != IDLE);
    assign io.sig_end   = sig_end_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_d[wr_ptr_q] = io.O_rd_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        base_d      = base_q;
        issued_d    = issued_q;
        deliv_d     = deliv_q;
        sig_end_d   = 1'b0;
        inflight_d  = issue;
        last_addr_d = issue ? next_addr : last_addr_q;

        case (state_q)
            IDLE: begin
                if (io.sig_start) begin
                    b_d      = b_clamped;
                    base_d   = io.O_base_addr;
                    issued_d = '0;
                    deliv_d  = '0;
                    if (b_clamped == '0) begin
                        state_d   = DONE;
                        sig_end_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (issue) begin
                    issued_d = issued_q + 1'b1;
                end
                if (pop) begin
                    deliv_d = deliv_q + 1'b1;
                end
                if (deliv_d == b_q) begin
                    state_d   = DONE;
                    sig_end_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            b_q         <= '0;
            base_q      <= '0;
            issued_q    <= '0;
            deliv_q     <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            sig_end_q   <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            base_q      <= base_d;
            issued_q    <= issued_d;
            deliv_q     <= deliv_d;
            last_addr_q <= last_addr_d;
            inflight_q  <= inflight_d;
            sig_end_q   <= sig_end_d;
            mem_q[0]    <= mem_d[0];
            mem_q[1]    <= mem_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end
endmodule

// File: tb/tb_o_row_fetch.sv
// Directed bench for o_row_fetch with an O-buffer model returning an address-derived row one cycle after each read.
module tb_o_row_fetch;
    localparam int ROW_DIM    = 16;
    localparam int COL_DIM    = 16;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 10;
    localparam int ROW_W      = ROW_DIM * DATA_WIDTH;
    localparam logic [ROW_W-1:0] GARBAGE = {(ROW_W/4){4'hE}};

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    o_row_fetch_if #(.ROW_DIM(ROW_DIM), .COL_DIM(COL_DIM), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) io ();

    o_row_fetch #(.ROW_DIM(ROW_DIM), .COL_DIM(COL_DIM), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    always #5 clk = ~clk;

    function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_WIDTH-1:0] a);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < ROW_DIM; i++) r[i*DATA_WIDTH +: DATA_WIDTH] = a[7:0] + 8'(i);
        r[ROW_W-1 -: 8] = {6'b0, a[9:8]} ^ 8'h5A;
        return r;
    endfunction

    // O-buffer: one-cycle read latency, junk on the bus otherwise.
    always @(posedge clk) io.O_rd_data <= io.O_rd_en ? row_of(io.O_rd_addr) : GARBAGE;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; io.sig_start = 1'b0; io.B = '0; io.O_base_addr = '0; io.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (io.O_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", io.O_rd_en); end
        checks++; if (io.O_rd_addr !== 10'h000) begin errors++; $display("FAIL reset_rd_addr: got %h want 000", io.O_rd_addr); end
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", io.out_valid); end
        checks++; if (io.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", io.out_data); end
        checks++; if (io.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", io.busy); end
        checks++; if (io.sig_end !== 1'b0) begin errors++; $display("FAIL reset_sig_end: got %b want 0", io.sig_end); end
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [ADDR_WIDTH-1:0] base;
        logic exp_en, exp_vld;
        base = 10'h010;
        next_cycle();
        io.sig_start = 1'b1; io.B = 5'd4; io.O_base_addr = base; io.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin next_cycle(); io.sig_start = 1'b0; end
            @(negedge clk);
            exp_en  = (c >= 1 && c <= 4);
            exp_vld = (c >= 3 && c <= 6);
            checks++; if (io.O_rd_en !== exp_en) begin errors++; $display("FAIL basic_rd_en c=%0d: got %b want %b", c, io.O_rd_en, exp_en); end
            if (exp_en) begin
                checks++; if (io.O_rd_addr !== base + 10'(c-1)) begin errors++; $display("FAIL basic_rd_addr c=%0d: got %h want %h", c, io.O_rd_addr, base + 10'(c-1)); end
            end
            checks++; if (io.out_valid !== exp_vld) begin errors++; $display("FAIL basic_out_valid c=%0d: got %b want %b", c, io.out_valid, exp_vld); end
            if (exp_vld) begin
                checks++; if (io.out_data !== row_of(base + 10'(c-3))) begin errors++; $display("FAIL basic_out_data c=%0d: got %h want %h", c, io.out_data, row_of(base + 10'(c-3))); end
            end
            checks++; if (io.sig_end !== (c == 7)) begin errors++; $display("FAIL basic_sig_end c=%0d: got %b", c, io.sig_end); end
            checks++; if (io.busy !== (c >= 1 && c <= 7)) begin errors++; $display("FAIL basic_busy c=%0d: got %b", c, io.busy); end
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR_WIDTH-1:0] base;
        logic [ROW_W-1:0] prev_data;
        logic prev_stall;
        int issued, deliv, last_xfer, end_cyc;
        base = 10'h100; issued = 0; deliv = 0; last_xfer = -1; end_cyc = -1;
        prev_stall = 1'b0; prev_data = '0;
        next_cycle();
        io.sig_start = 1'b1; io.B = 5'd8; io.O_base_addr = base; io.out_ready = 1'b0;
        for (int c = 0; c < 60 && end_cyc < 0; c++) begin
            if (c > 0) begin next_cycle(); io.sig_start = 1'b0; io.out_ready = (c % 2 == 1); end
            @(negedge clk);
            if (prev_stall) begin
                checks++; if (io.out_valid !== 1'b1 || io.out_data !== prev_data) begin errors++; $display("FAIL bp_stable c=%0d: got vld=%b data=%h want vld=1 data=%h", c, io.out_valid, io.out_data, prev_data); end
            end
            if (io.O_rd_en === 1'b1) begin
                checks++; if (io.O_rd_addr !== base + 10'(issued)) begin errors++; $display("FAIL bp_rd_addr c=%0d: got %h want %h", c, io.O_rd_addr, base + 10'(issued)); end
                issued++;
            end
            if (io.out_valid === 1'b1 && io.out_ready === 1'b1) begin
                checks++; if (io.out_data !== row_of(base + 10'(deliv))) begin errors++; $display("FAIL bp_out_data c=%0d: got %h want %h", c, io.out_data, row_of(base + 10'(deliv))); end
                deliv++; last_xfer = c;
            end
            checks++; if (issued - deliv > 2) begin errors++; $display("FAIL bp_occupancy c=%0d: got %0d outstanding want <=2", c, issued - deliv); end
            if (io.sig_end === 1'b1) end_cyc = c;
            prev_stall = io.out_valid && !io.out_ready;
            prev_data  = io.out_data;
        end
        checks++; if (end_cyc < 0) begin errors++; $display("FAIL bp_timeout: got no sig_end want sig_end within 60 cycles"); end
        checks++; if (deliv != 8) begin errors++; $display("FAIL bp_delivered: got %0d want 8", deliv); end
        checks++; if (issued != 8) begin errors++; $display("FAIL bp_issued: got %0d want 8", issued); end
        checks++; if (end_cyc != last_xfer + 1) begin errors++; $display("FAIL bp_sig_end_cycle: got %0d want %0d", end_cyc, last_xfer + 1); end
    endtask

    task automatic test_wrap_clamp();
        logic [ADDR_WIDTH-1:0] base;
        int reads, deliv, end_cyc;
        base = 10'h3FE; reads = 0; deliv = 0; end_cyc = -1;
        next_cycle();
        io.sig_start = 1'b1; io.B = 5'd20; io.O_base_addr = base; io.out_ready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            if (c > 0) begin next_cycle(); io.sig_start = 1'b0; end
            @(negedge clk);
            if (io.O_rd_en === 1'b1) begin
                checks++; if (io.O_rd_addr !== base + 10'(reads)) begin errors++; $display("FAIL wrap_rd_addr c=%0d: got %h want %h", c, io.O_rd_addr, base + 10'(reads)); end
                reads++;
            end
            if (io.out_valid === 1'b1) deliv++;
            if (io.sig_end === 1'b1 && end_cyc < 0) end_cyc = c;
        end
        checks++; if (reads != 16) begin errors++; $display("FAIL wrap_reads: got %0d want 16", reads); end
        checks++; if (deliv != 16) begin errors++; $display("FAIL wrap_delivered: got %0d want 16", deliv); end
        checks++; if (end_cyc != 19) begin errors++; $display("FAIL wrap_sig_end_cycle: got %0d want 19", end_cyc); end
    endtask

    task automatic test_zero_len();
        next_cycle();
        io.sig_start = 1'b1; io.B = 5'd0; io.O_base_addr = 10'h055; io.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin next_cycle(); io.sig_start = 1'b0; end
            @(negedge clk);
            checks++; if (io.O_rd_en !== 1'b0) begin errors++; $display("FAIL zero_rd_en c=%0d: got %b want 0", c, io.O_rd_en); end
            checks++; if (io.sig_end !== (c == 1)) begin errors++; $display("FAIL zero_sig_end c=%0d: got %b", c, io.sig_end); end
            checks++; if (io.busy !== (c == 1)) begin errors++; $display("FAIL zero_busy c=%0d: got %b", c, io.busy); end
        end
    endtask

    task automatic test_start_busy();
        logic [ADDR_WIDTH-1:0] base;
        logic exp_en, exp_vld;
        base = 10'h200;
        next_cycle();
        io.sig_start = 1'b1; io.B = 5'd3; io.O_base_addr = base; io.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                next_cycle();
                io.sig_start = (c == 2);
                if (c == 2) begin io.B = 5'd6; io.O_base_addr = 10'h300; end
            end
            @(negedge clk);
            exp_en  = (c >= 1 && c <= 3);
            exp_vld = (c >= 3 && c <= 5);
            checks++; if (io.O_rd_en !== exp_en) begin errors++; $display("FAIL busy_start_rd_en c=%0d: got %b want %b", c, io.O_rd_en, exp_en); end
            if (exp_en) begin
                checks++; if (io.O_rd_addr !== base + 10'(c-1)) begin errors++; $display("FAIL busy_start_rd_addr c=%0d: got %h want %h", c, io.O_rd_addr, base + 10'(c-1)); end
            end
            if (exp_vld) begin
                checks++; if (io.out_data !== row_of(base + 10'(c-3))) begin errors++; $display("FAIL busy_start_out_data c=%0d: got %h want %h", c, io.out_data, row_of(base + 10'(c-3))); end
            end
            checks++; if (io.sig_end !== (c == 6)) begin errors++; $display("FAIL busy_start_sig_end c=%0d: got %b", c, io.sig_end); end
            checks++; if (io.busy !== (c >= 1 && c <= 6)) begin errors++; $display("FAIL busy_start_busy c=%0d: got %b", c, io.busy); end
        end
    endtask

    task automatic test_reset_mid();
        logic [ADDR_WIDTH-1:0] base;
        logic exp_en, exp_vld;
        next_cycle();
        io.sig_start = 1'b1; io.B = 5'd8; io.O_base_addr = 10'h040; io.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin next_cycle(); io.sig_start = 1'b0; end
            if (c == 3) reset = 1'b0;
            if (c == 4) reset = 1'b1;
            @(negedge clk);
            if (c == 3) begin
                checks++; if (io.O_rd_en !== 1'b1 || io.O_rd_addr !== 10'h042) begin errors++; $display("FAIL rst_mid_pre c=3: got en=%b addr=%h want en=1 addr=042", io.O_rd_en, io.O_rd_addr); end
            end
            if (c == 4) begin
                checks++; if (io.O_rd_en !== 1'b0) begin errors++; $display("FAIL rst_mid_rd_en: got %b want 0", io.O_rd_en); end
                checks++; if (io.O_rd_addr !== 10'h000) begin errors++; $display("FAIL rst_mid_rd_addr: got %h want 000", io.O_rd_addr); end
                checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", io.out_valid); end
                checks++; if (io.out_data !== '0) begin errors++; $display("FAIL rst_mid_out_data: got %h want 0", io.out_data); end
                checks++; if (io.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", io.busy); end
                checks++; if (io.sig_end !== 1'b0) begin errors++; $display("FAIL rst_mid_sig_end: got %b want 0", io.sig_end); end
            end
            if (c == 5) begin
                checks++; if (io.out_valid !== 1'b0 || io.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_stale: got vld=%b busy=%b want 0 0", io.out_valid, io.busy); end
            end
        end
        base = 10'h080;
        next_cycle();
        io.sig_start = 1'b1; io.B = 5'd2; io.O_base_addr = base;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin next_cycle(); io.sig_start = 1'b0; end
            @(negedge clk);
            exp_en  = (c >= 1 && c <= 2);
            exp_vld = (c >= 3 && c <= 4);
            checks++; if (io.O_rd_en !== exp_en) begin errors++; $display("FAIL rst_fresh_rd_en c=%0d: got %b want %b", c, io.O_rd_en, exp_en); end
            if (exp_en) begin
                checks++; if (io.O_rd_addr !== base + 10'(c-1)) begin errors++; $display("FAIL rst_fresh_rd_addr c=%0d: got %h want %h", c, io.O_rd_addr, base + 10'(c-1)); end
            end
            checks++; if (io.out_valid !== exp_vld) begin errors++; $display("FAIL rst_fresh_out_valid c=%0d: got %b want %b", c, io.out_valid, exp_vld); end
            if (exp_vld) begin
                checks++; if (io.out_data !== row_of(base + 10'(c-3))) begin errors++; $display("FAIL rst_fresh_out_data c=%0d: got %h want %h", c, io.out_data, row_of(base + 10'(c-3))); end
            end
            checks++; if (io.sig_end !== (c == 5)) begin errors++; $display("FAIL rst_fresh_sig_end c=%0d: got %b", c, io.sig_end); end
            checks++; if (io.busy !== (c >= 1 && c <= 5)) begin errors++; $display("FAIL rst_fresh_busy c=%0d: got %b", c, io.busy); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_clamp();
        test_zero_len();
        test_start_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/o_row_fetch.md
O_ROW_FETCH -- requirements
Module: o_row_fetch

Interface
REQ-001 Parameters SHALL be ROW_DIM (default 16, elements per row), COL_DIM (default 16, max rows per transfer), DATA_WIDTH (default 8, bits per element) and ADDR_WIDTH (default 10, O-buffer address bits).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 sig_start  input  1  one-cycle pulse that starts a transfer; sampled only in IDLE.
REQ-005 B  input  $clog2(COL_DIM)+1  number of rows to fetch; captured on an accepted sig_start.
REQ-006 O_base_addr  input  ADDR_WIDTH  first O-buffer row address; captured on an accepted sig_start.
REQ-007 O_rd_en  output  1  O-buffer read strobe.
REQ-008 O_rd_addr  output  ADDR_WIDTH  O-buffer read address.
REQ-009 O_rd_data  input  ROW_DIM*DATA_WIDTH  O-buffer read data; valid exactly 1 cycle after O_rd_en.
REQ-010 out_valid  output  1  out_data holds a valid row for the transpose stage.
REQ-011 out_ready  input  1  the transpose stage accepts a row; a transfer occurs when out_valid && out_ready.
REQ-012 out_data  output  ROW_DIM*DATA_WIDTH  row data, element 0 in the LSBs, passed unmodified from O_rd_data.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 sig_end  output  1  one-cycle pulse when all B rows have been delivered.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH and DONE; in IDLE, sig_start moves the FSM to FETCH, or to DONE when the captured B is 0.
REQ-016 On sig_start, the block SHALL clamp a B greater than COL_DIM to COL_DIM before capture.
REQ-017 The k-th read (k = 0..B-1) SHALL use O_rd_addr = O_base_addr + k modulo 2^ADDR_WIDTH, so 0x3FF is followed by 0x000.
REQ-018 Reads SHALL be issued in order, one per cycle at most, and only while the issued-row count is less than B.
REQ-019 Read data SHALL be captured into a 2-entry FIFO at the end of the cycle after its O_rd_en; out_valid and out_data SHALL be driven from the FIFO head.
REQ-020 A read SHALL be issued only when (occupancy - pop_this_cycle + inflight) < 2, so the FIFO never overflows and no response is ever dropped.
REQ-021 With out_ready held high, throughput SHALL be 1 row per cycle: first O_rd_en in cycle 1 after sig_start (cycle 0), first out_valid in cycle 3, last row in cycle 2+B.
REQ-022 While out_ready is low, out_valid and out_data SHALL stay stable, and reads SHALL stop once the FIFO plus in-flight rows reach 2.
REQ-023 Once the delivered-row count equals B, the FSM SHALL go from FETCH to DONE.
REQ-024 DONE SHALL last one cycle with sig_end=1 and then return to IDLE.
REQ-025 sig_start while busy SHALL be ignored, with no change to B, the base address or the counters.
REQ-026 O_rd_addr SHALL hold its last value when O_rd_en is 0; O_rd_data SHALL be ignored in any cycle not 1 cycle after O_rd_en.

Reset
REQ-027 While reset=0 at a clock edge, the block SHALL clear to: state IDLE; O_rd_en=0, O_rd_addr=0, out_valid=0, out_data=0, busy=0, sig_end=0; FIFO, in-flight flag and counters cleared.
REQ-028 Reset mid-transfer SHALL abort the transfer, and any read response arriving in the cycle after reset SHALL be discarded.

Verification
REQ-029 Basic: B=4, base 0x010, out_ready=1 -> reads 0x010..0x013 in cycles 1-4; rows delivered in cycles 3-6 in order; sig_end in cycle 7.
REQ-030 Backpressure: B=8, out_ready toggled 1/0 every cycle -> all 8 rows delivered in order, none lost or duplicated, in-flight plus FIFO rows never exceed 2, sig_end after the 8th transfer.
REQ-031 Wrap and clamp: base 0x3FE, B=20 with COL_DIM=16 -> exactly 16 reads, at 0x3FE, 0x3FF, 0x000..0x00D.
REQ-032 Zero length: B=0 -> no O_rd_en, sig_end in cycle 1, busy high for only that cycle.
REQ-033 Reset mid-operation: reset=0 in cycle 3 of a B=8 transfer -> next cycle all outputs at reset values; a new sig_start with B=2 behaves as in a fresh transfer.
REQ-034 Start while busy: a second sig_start with different B and base during FETCH -> ignored; the original transfer completes unchanged.
